osd_ram_write_scheduler: RTL and testbench

- Owns the single write port of the OSD character RAM (1024 x 8).
- Arbitrates between two requesters:
  - byte writes decoded by the I2C register interface;
  - an internal fill engine that clears or fills a contiguous OSD region with one character.
- The fill engine is used for fast screen clears, so the host does not need 1024 I2C transactions.
- Sits between the I2C register block and the OSD RAM write port in the video clock domain.

---
 rtl/osd_ram_write_scheduler_if.sv | 46 ++++
 rtl/osd_ram_write_scheduler.sv | 124 ++++++++++++
 tb/tb_osd_ram_write_scheduler.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/osd_ram_write_scheduler_if.sv
// OSD RAM write scheduler bundle: I2C writes, fill control, RAM port.
// Optional stall_count member exists only with OSD_FILL_STALL_COUNT_EN.
interface osd_ram_write_scheduler_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 11
);
  logic              i2c_wren;
  logic [ADDR_W-1:0] i2c_wraddress;
  logic [DATA_W-1:0] i2c_data;
  logic              fill_start;
  logic [ADDR_W-1:0] fill_base;
  logic [LEN_W-1:0]  fill_len;
  logic [DATA_W-1:0] fill_char;
  logic              fill_abort;
  logic              busy;
  logic              done;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_wraddress;
  logic [DATA_W-1:0] ram_data;
`ifdef OSD_FILL_STALL_COUNT_EN
  logic [15:0]       stall_count;
`endif

  modport master (
    output i2c_wren, i2c_wraddress, i2c_data,
    output fill_start, fill_base, fill_len,
    output fill_char, fill_abort,
    input  busy, done,
    input  ram_wren, ram_wraddress, ram_data
`ifdef OSD_FILL_STALL_COUNT_EN
    , input stall_count
`endif
  );

  modport slave (
    input  i2c_wren, i2c_wraddress, i2c_data,
    input  fill_start, fill_base, fill_len,
    input  fill_char, fill_abort,
    output busy, done,
    output ram_wren, ram_wraddress, ram_data
`ifdef OSD_FILL_STALL_COUNT_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/osd_ram_write_scheduler.sv
// Single OSD RAM write port: I2C byte writes beat a region fill engine.
// Ports: clk, reset_n, bus (slave). Macro OSD_FILL_STALL_COUNT_EN adds stall_count.
module osd_ram_write_scheduler #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 11
) (
  input logic                       clk,
  input logic                       reset_n,
  osd_ram_write_scheduler_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] char_q, char_d;
  logic              done_q, done_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fill_wr;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    char_d  = char_q;
    done_d  = 1'b0;
    fill_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fill_start) begin
          if (bus.fill_len != '0) begin
            cur_d   = bus.fill_base;
            rem_d   = bus.fill_len;
            char_d  = bus.fill_char;
            state_d = FILL;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (bus.fill_abort) begin
          state_d = FINISH;
        end else if (!bus.i2c_wren) begin
          fill_wr = 1'b1;
          cur_d   = cur_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // done is registered so it lines up with the FINISH state
    if (state_d == FINISH) done_d = 1'b1;
  end

  always_comb begin
    wren_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (bus.i2c_wren) begin
      wren_d = 1'b1;
      addr_d = bus.i2c_wraddress;
      data_d = bus.i2c_data;
    end else if (fill_wr) begin
      wren_d = 1'b1;
      addr_d = cur_q;
      data_d = char_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      char_q  <= '0;
      done_q  <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      char_q  <= char_d;
      done_q  <= done_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign bus.ram_wren      = wren_q;
  assign bus.ram_wraddress = addr_q;
  assign bus.ram_data      = data_q;

`ifdef OSD_FILL_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && bus.fill_start)
      stall_d = '0;
    else if (state_q == FILL && bus.i2c_wren && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign bus.stall_count = stall_q;
`endif
endmodule

// File: tb/tb_osd_ram_write_scheduler.sv
// Directed bench for osd_ram_write_scheduler.
// Fill sequences, priority stalls, abort, zero length and reset.
module tb_osd_ram_write_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  osd_ram_write_scheduler_if #(.ADDR_W(10), .DATA_W(8), .LEN_W(11)) bus ();

  osd_ram_write_scheduler #(.ADDR_W(10), .DATA_W(8), .LEN_W(11)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int q_addr[$];
  int q_data[$];
  int q_cyc[$];
  int n_busy, n_done, done_cyc;
  int stall_idx = -1;
  int abort_idx = -1;
  int inj_addr = 0;
  int inj_data = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input int base, input int len, input int ch);
    bus.fill_start = 1'b1;
    bus.fill_base  = 10'(base);
    bus.fill_len   = 11'(len);
    bus.fill_char  = 8'(ch);
    tick();
    bus.fill_start = 1'b0;
  endtask

  // Sample index 0 is the first cycle after fill_start was clocked in.
  task automatic collect(input int limit);
    int i;
    i = 0;
    q_addr.delete(); q_data.delete(); q_cyc.delete();
    n_busy = 0; n_done = 0; done_cyc = -1;
    do begin
      if (bus.busy) n_busy++;
      if (bus.done) begin n_done++; done_cyc = i; end
      if (bus.ram_wren) begin
        q_addr.push_back(int'(bus.ram_wraddress));
        q_data.push_back(int'(bus.ram_data));
        q_cyc.push_back(i);
      end
      bus.i2c_wren      = (i == stall_idx);
      bus.i2c_wraddress = 10'(inj_addr);
      bus.i2c_data      = 8'(inj_data);
      bus.fill_abort    = (i == abort_idx);
      tick();
      bus.i2c_wren   = 1'b0;
      bus.fill_abort = 1'b0;
      i++;
    end while ((bus.busy || bus.ram_wren || bus.done) && i < limit);
    stall_idx = -1;
    abort_idx = -1;
    n_checks++;
    if (i >= limit) begin
      n_fail++;
      $display("FAIL collect_timeout: ran %0d cycles, limit %0d", i, limit);
    end
  endtask

  task automatic test_reset();
    bus.i2c_wren = 0; bus.i2c_wraddress = 0; bus.i2c_data = 0;
    bus.fill_start = 0; bus.fill_base = 0; bus.fill_len = 0;
    bus.fill_char = 0; bus.fill_abort = 0;
    reset_n = 1'b0;
    #12;
    n_checks++;
    if ({bus.busy, bus.done, bus.ram_wren, bus.ram_wraddress, bus.ram_data}
        !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b wren=%b a=%0d d=%0h want all 0",
               bus.busy, bus.done, bus.ram_wren, bus.ram_wraddress, bus.ram_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_fill();
    int bad;
    start_fill(0, 1024, 8'h20);
    collect(1200);
    n_checks++;
    if (q_addr.size() != 1024) begin
      n_fail++;
      $display("FAIL full_count: got %0d writes want 1024", q_addr.size());
    end
    bad = 0;
    foreach (q_addr[i])
      if (q_addr[i] != i || q_data[i] != 8'h20 || q_cyc[i] != i + 1) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL full_seq: got %0d bad writes want 0", bad);
    end
    n_checks++;
    if (n_done != 1 || done_cyc != 1024) begin
      n_fail++;
      $display("FAIL full_done: got %0d pulses at %0d want 1 at 1024", n_done, done_cyc);
    end
    n_checks++;
    if (n_busy != 1025) begin
      n_fail++;
      $display("FAIL full_busy: got %0d busy cycles want 1025", n_busy);
    end
  endtask

  task automatic test_wrap();
    int exp_a[8] = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};
    int bad;
    start_fill(1020, 8, 8'hAA);
    collect(50);
    n_checks++;
    if (q_addr.size() != 8) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d want 8", q_addr.size());
    end
    bad = 0;
    foreach (q_addr[i])
      if (i < 8 && (q_addr[i] != exp_a[i] || q_data[i] != 8'hAA)) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wrap_seq: got %0d bad writes want 0", bad);
    end
    n_checks++;
    if (n_done != 1 || done_cyc != 8) begin
      n_fail++;
      $display("FAIL wrap_done: got %0d at %0d want 1 at 8", n_done, done_cyc);
    end
  endtask

  task automatic test_stall();
    int exp_a[5] = '{16, 5, 17, 18, 19};
    int exp_d[5] = '{8'h41, 8'h7E, 8'h41, 8'h41, 8'h41};
    int bad;
    start_fill(16, 4, 8'h41);
    stall_idx = 1; inj_addr = 5; inj_data = 8'h7E;
    collect(50);
    n_checks++;
    if (q_addr.size() != 5) begin
      n_fail++;
      $display("FAIL stall_count_wr: got %0d want 5", q_addr.size());
    end
    bad = 0;
    foreach (q_addr[i])
      if (i < 5 && (q_addr[i] != exp_a[i] || q_data[i] != exp_d[i]
                    || q_cyc[i] != i + 1)) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_seq: got %0d bad writes want 0", bad);
    end
    n_checks++;
    if (n_done != 1 || done_cyc != 5) begin
      n_fail++;
      $display("FAIL stall_done: got %0d at %0d want 1 at 5", n_done, done_cyc);
    end
`ifdef OSD_FILL_STALL_COUNT_EN
    n_checks++;
    if (bus.stall_count !== 16'd1) begin
      n_fail++;
      $display("FAIL stall_counter: got %0d want 1", bus.stall_count);
    end
`endif
  endtask

  task automatic test_zero_len();
    start_fill(40, 0, 8'h55);
    collect(20);
    n_checks++;
    if (q_addr.size() != 0 || n_busy != 0) begin
      n_fail++;
      $display("FAIL zero_len: got %0d writes %0d busy want 0 0", q_addr.size(), n_busy);
    end
    n_checks++;
    if (n_done != 1 || done_cyc != 0) begin
      n_fail++;
      $display("FAIL zero_done: got %0d at %0d want 1 at 0", n_done, done_cyc);
    end
  endtask

  task automatic test_abort();
    start_fill(200, 100, 8'h33);
    abort_idx = 3;
    collect(200);
    n_checks++;
    if (q_addr.size() != 3 || q_addr[0] != 200 || q_addr[2] != 202) begin
      n_fail++;
      $display("FAIL abort_writes: got %0d writes want 3 at 200..202", q_addr.size());
    end
    n_checks++;
    if (n_done != 1 || done_cyc != 4) begin
      n_fail++;
      $display("FAIL abort_done: got %0d at %0d want 1 at 4", n_done, done_cyc);
    end
    start_fill(7, 2, 8'h55);
    collect(20);
    n_checks++;
    if (q_addr.size() != 2 || q_addr[0] != 7 || q_addr[1] != 8
        || q_data[1] != 8'h55 || n_done != 1) begin
      n_fail++;
      $display("FAIL abort_refill: got %0d writes %0d done want 2 writes 1 done",
               q_addr.size(), n_done);
    end
  endtask

  task automatic test_back_to_back();
    start_fill(300, 10, 8'h11);
    stall_idx = 1; abort_idx = 1; inj_addr = 9; inj_data = 8'hE1;
    collect(50);
    n_checks++;
    if (q_addr.size() != 2 || q_addr[0] != 300 || q_addr[1] != 9
        || q_data[1] != 8'hE1) begin
      n_fail++;
      $display("FAIL abort_i2c_writes: got %0d writes want 300 then 9", q_addr.size());
    end
    n_checks++;
    if (n_done != 1 || done_cyc != 2) begin
      n_fail++;
      $display("FAIL abort_i2c_done: got %0d at %0d want 1 at 2", n_done, done_cyc);
    end
  endtask

  task automatic test_reset_mid_fill();
    int dn;
    start_fill(500, 50, 8'h99);
    repeat (5) tick();
    reset_n = 1'b0;
    #2;
    n_checks++;
    if ({bus.busy, bus.done, bus.ram_wren, bus.ram_wraddress, bus.ram_data}
        !== 21'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%b wren=%b a=%0d d=%0h want all 0",
               bus.busy, bus.ram_wren, bus.ram_wraddress, bus.ram_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    dn = 0;
    repeat (4) begin
      tick();
      if (bus.done || bus.busy || bus.ram_wren) dn++;
    end
    n_checks++;
    if (dn != 0) begin
      n_fail++;
      $display("FAIL midreset_idle: got %0d active cycles want 0", dn);
    end
    bus.i2c_wren = 1'b1; bus.i2c_wraddress = 10'h155; bus.i2c_data = 8'hC3;
    tick();
    bus.i2c_wren = 1'b0;
    n_checks++;
    if (bus.ram_wren !== 1'b1 || bus.ram_wraddress !== 10'h155
        || bus.ram_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL midreset_i2c: got wren=%b a=%0h d=%0h want 1 155 c3",
               bus.ram_wren, bus.ram_wraddress, bus.ram_data);
    end
    tick();
    n_checks++;
    if (bus.ram_wren !== 1'b0 || bus.ram_wraddress !== 10'h155
        || bus.ram_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL idle_hold: got wren=%b a=%0h d=%0h want 0 155 c3",
               bus.ram_wren, bus.ram_wraddress, bus.ram_data);
    end
  endtask

  initial begin
    test_reset();
    test_full_fill();
    test_wrap();
    test_stall();
    test_zero_len();
    test_abort();
    test_back_to_back();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
